// File: rtl/sine_rom_seq.sv
// Sine sample sequencer. A phase accumulator walks a quarter-wave
// magnitude ROM. Quadrant folding of the address and negation of the
// magnitude rebuild a full signed sine. Samples leave through a
// valid/ready register stage.
//
// state | meaning
// IDLE  | waiting for start; sample register keeps its last value
// RUN   | stepping the phase and presenting one sample per handshake
// DRAIN | stop seen while a sample was still pending; waiting for ready
//
// The quadrant/index decode needs PHASEW >= ADDRW+2.
module sine_rom_seq #(
   parameter int WIDTH  = 8,
   parameter int ADDRW  = 8,
   parameter int PHASEW = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic [PHASEW-1:0] freq_word,
   output logic [ADDRW-1:0]  rom_addr,
   input  logic [WIDTH-1:0]  rom_data,
   output logic [WIDTH:0]    sample,
   output logic              sample_valid,
   input  logic              sample_ready,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t             state_q;
   state_t             state_nxt;
   logic [PHASEW-1:0]  phase_q;
   logic [PHASEW-1:0]  freq_q;
   logic [1:0]         quad;
   logic [ADDRW-1:0]   idx;
   logic [WIDTH:0]     rom_ext;
   logic [WIDTH:0]     sample_nxt;
   logic               can_adv;
   logic               accept;
   logic               advance;
   logic               clr_valid;

   // Quadrants 1 and 3 walk the table backwards; 2 and 3 are negated.
   assign quad       = phase_q[PHASEW-1 -: 2];
   assign idx        = phase_q[PHASEW-3 -: ADDRW];
   assign rom_addr   = quad[0] ? ~idx : idx;
   assign rom_ext    = {1'b0, rom_data};
   assign sample_nxt = quad[1] ? ({(WIDTH+1){1'b0}} - rom_ext) : rom_ext;

   // The output slot is free when it is empty or is being taken this cycle.
   assign can_adv = !sample_valid || sample_ready;
   assign busy    = (state_q != IDLE);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Next-state and datapath strobes; stop takes priority over advancing.
   always_comb begin
      state_nxt = state_q;
      accept    = 1'b0;
      advance   = 1'b0;
      clr_valid = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !stop) begin
               state_nxt = RUN;
               accept    = 1'b1;
            end
         end
         RUN: begin
            if (stop) begin
               if (can_adv) begin
                  state_nxt = IDLE;
                  clr_valid = 1'b1;
               end else begin
                  state_nxt = DRAIN;
               end
            end else if (can_adv) begin
               advance = 1'b1;
            end
         end
         DRAIN: begin
            if (sample_ready) begin
               state_nxt = IDLE;
               clr_valid = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Phase accumulator and output register. The sample register is left
   // alone outside an advance so its last value stays visible in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q      <= '0;
         freq_q       <= '0;
         sample       <= '0;
         sample_valid <= 1'b0;
      end else begin
         if (accept) begin
            phase_q <= '0;
            freq_q  <= freq_word;
         end
         if (advance) begin
            sample       <= sample_nxt;
            sample_valid <= 1'b1;
            phase_q      <= phase_q + freq_q;
         end
         if (clr_valid) begin
            sample_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sine_rom_seq.sv
module tb_sine_rom_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        stop;
   logic [15:0] freq_word;
   logic [7:0]  rom_addr;
   logic [7:0]  rom_data;
   logic [8:0]  sample;
   logic        sample_valid;
   logic        sample_ready;
   logic        busy;

   int n_total;
   int n_pass;

   sine_rom_seq #(.WIDTH(8), .ADDRW(8), .PHASEW(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .stop         (stop),
      .freq_word    (freq_word),
      .rom_addr     (rom_addr),
      .rom_data     (rom_data),
      .sample       (sample),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .busy         (busy)
   );

   // Identity ROM: rom[k] = k.
   assign rom_data = rom_addr;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Expected ROM address for a phase (8-bit index, quadrant folding).
   function automatic logic [7:0] m_addr(input logic [15:0] ph);
      logic [7:0] i;
      i = ph[13:6];
      return ph[14] ? 8'(8'd255 - i) : i;
   endfunction

   // Expected signed sample for a phase with the identity ROM.
   function automatic logic [8:0] m_samp(input logic [15:0] ph);
      logic [8:0] d;
      d = {1'b0, m_addr(ph)};
      return ph[15] ? 9'(9'd0 - d) : d;
   endfunction

   logic [7:0] q_addr [4];
   logic [8:0] q_samp [4];

   initial begin
      n_total      = 0;
      n_pass       = 0;
      rst_n        = 1'b0;
      start        = 1'b0;
      stop         = 1'b0;
      freq_word    = 16'h0000;
      sample_ready = 1'b0;
      q_addr = '{8'd0, 8'd255, 8'd0, 8'd255};
      q_samp = '{9'h000, 9'h0FF, 9'h000, 9'h101};

      // Reset state
      repeat (2) tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(sample_valid), 32'd0);
      chk("rst_sample", 32'(sample), 32'd0);
      chk("rst_addr", 32'(rom_addr), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("idle_busy", 32'(busy), 32'd0);

      // Quarter-turn steps: 0, +255, 0, -255
      freq_word    = 16'h4000;
      sample_ready = 1'b1;
      start        = 1'b1;
      tick();
      start     = 1'b0;
      freq_word = 16'h1234;
      chk("q_busy", 32'(busy), 32'd1);
      chk("q_valid0", 32'(sample_valid), 32'd0);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("q_addr%0d", k), 32'(rom_addr), 32'(q_addr[k]));
         tick();
         chk($sformatf("q_valid%0d", k), 32'(sample_valid), 32'd1);
         chk($sformatf("q_samp%0d", k), 32'(sample), 32'(q_samp[k]));
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("q_stop_busy", 32'(busy), 32'd0);
      chk("q_stop_valid", 32'(sample_valid), 32'd0);
      chk("q_retain", 32'(sample), 32'h101);
      tick();
      chk("q_idle_busy", 32'(busy), 32'd0);

      // Fine step 0x0040: full table sweep up then down
      freq_word = 16'h0040;
      start     = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 300; k++) begin
         chk($sformatf("f_addr%0d", k), 32'(rom_addr), 32'(m_addr(16'(k * 64))));
         tick();
         chk($sformatf("f_samp%0d", k), 32'(sample), 32'(m_samp(16'(k * 64))));
         if (k == 256) chk("f_samp256", 32'(sample), 32'h0FF);
         if (k == 255) chk("f_addr_top", 32'(rom_addr), 32'd255);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("f_stop_busy", 32'(busy), 32'd0);

      // Back-pressure for 5 cycles mid-stream
      freq_word = 16'h0100;
      start     = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("s_samp%0d", k), 32'(sample), 32'(m_samp(16'(k * 256))));
      end
      sample_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk($sformatf("s_hold_samp%0d", c), 32'(sample), 32'(m_samp(16'h0200)));
         chk($sformatf("s_hold_addr%0d", c), 32'(rom_addr), 32'(m_addr(16'h0300)));
         chk($sformatf("s_hold_valid%0d", c), 32'(sample_valid), 32'd1);
      end
      sample_ready = 1'b1;
      for (int k = 3; k < 6; k++) begin
         chk($sformatf("s_res_addr%0d", k), 32'(rom_addr), 32'(m_addr(16'(k * 256))));
         tick();
         chk($sformatf("s_res_samp%0d", k), 32'(sample), 32'(m_samp(16'(k * 256))));
      end

      // Stop while the sample is pending, then drain
      sample_ready = 1'b0;
      stop         = 1'b1;
      tick();
      stop = 1'b0;
      chk("d_busy", 32'(busy), 32'd1);
      chk("d_valid", 32'(sample_valid), 32'd1);
      chk("d_samp", 32'(sample), 32'(m_samp(16'h0500)));
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("d_start_busy", 32'(busy), 32'd1);
      chk("d_start_samp", 32'(sample), 32'(m_samp(16'h0500)));
      sample_ready = 1'b1;
      tick();
      chk("d_end_busy", 32'(busy), 32'd0);
      chk("d_end_valid", 32'(sample_valid), 32'd0);
      chk("d_end_addr", 32'(rom_addr), 32'(m_addr(16'h0600)));
      tick();
      chk("d_idle_busy", 32'(busy), 32'd0);

      // start with stop in IDLE is ignored; start alone then runs
      freq_word = 16'h4040;
      start     = 1'b1;
      stop      = 1'b1;
      tick();
      chk("ss_busy", 32'(busy), 32'd0);
      chk("ss_valid", 32'(sample_valid), 32'd0);
      stop = 1'b0;
      tick();
      start = 1'b0;
      chk("sa_busy", 32'(busy), 32'd1);
      chk("sa_valid0", 32'(sample_valid), 32'd0);
      tick();
      chk("sa_valid1", 32'(sample_valid), 32'd1);
      chk("sa_samp", 32'(sample), 32'h000);
      chk("sa_addr", 32'(rom_addr), 32'd254);
      tick();
      chk("sa_samp2", 32'(sample), 32'h0FE);
      chk("sa_addr2", 32'(rom_addr), 32'd2);

      // Asynchronous reset mid-cycle while running
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_busy", 32'(busy), 32'd0);
      chk("ar_valid", 32'(sample_valid), 32'd0);
      chk("ar_samp", 32'(sample), 32'd0);
      chk("ar_addr", 32'(rom_addr), 32'd0);
      tick();
      #2;
      rst_n = 1'b1;
      repeat (2) tick();
      chk("ar_after_busy", 32'(busy), 32'd0);
      chk("ar_after_valid", 32'(sample_valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
